// File: rtl/ccu_ctrl_snoop_collector_if.sv
// Snoop collector bus bundle: CR/CD channels from the snooped caches,
// the requester R path and the memory-unit CD push path.
interface ccu_ctrl_snoop_collector_if #(
   parameter int unsigned NoMstPorts   = 4,
   parameter int unsigned AxiDataWidth = 64
);
   logic [NoMstPorts-1:0]              cr_valid_i;
   logic [5*NoMstPorts-1:0]            cr_resp_i;
   logic [NoMstPorts-1:0]              cr_ready_o;
   logic [NoMstPorts-1:0]              cd_valid_i;
   logic [AxiDataWidth*NoMstPorts-1:0] cd_data_i;
   logic [NoMstPorts-1:0]              cd_last_i;
   logic [NoMstPorts-1:0]              cd_ready_o;
   logic [AxiDataWidth-1:0]            r_data_o;
   logic                               r_last_o;
   logic                               r_valid_o;
   logic                               r_ready_i;
   logic [AxiDataWidth-1:0]            cd_o;
   logic                               cd_handshake_o;
   logic                               cd_fifo_full_i;

   modport master (
      input  cr_valid_i, cr_resp_i, cd_valid_i, cd_data_i, cd_last_i, r_ready_i, cd_fifo_full_i,
      output cr_ready_o, cd_ready_o, r_data_o, r_last_o, r_valid_o, cd_o, cd_handshake_o
   );

   modport slave (
      output cr_valid_i, cr_resp_i, cd_valid_i, cd_data_i, cd_last_i, r_ready_i, cd_fifo_full_i,
      input  cr_ready_o, cd_ready_o, r_data_o, r_last_o, r_valid_o, cd_o, cd_handshake_o
   );
endinterface

// File: rtl/ccu_ctrl_snoop_collector.sv
// Collects CR responses from a masked set of snooped ports, streams the winning
// responder's line to the requester and/or memory unit, and drains all other lines.
module ccu_ctrl_snoop_collector #(
   parameter int unsigned NoMstPorts      = 4,
   parameter int unsigned AxiDataWidth    = 64,
   parameter int unsigned DcacheLineWidth = 128
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [NoMstPorts-1:0] port_mask_i,
   input  logic                  fwd_r_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [4:0]            resp_o,
   output logic                  data_o,
   output logic                  wb_o,
   ccu_ctrl_snoop_collector_if.master bus
);
   localparam int unsigned LineWords = DcacheLineWidth / AxiDataWidth;
   localparam int unsigned CntW      = (LineWords > 1) ? $clog2(LineWords) : 1;
   localparam int unsigned IdxW      = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1;

   typedef enum logic [1:0] {IDLE, COLLECT, STREAM, DONE} state_e;

   state_e                  state_reg;
   logic [NoMstPorts-1:0]   pending_reg, dt_reg, drain_reg;
   logic [4:0]              resp_reg;
   logic                    fwd_reg, rsel_reg, wb_reg, data_reg, win_active_reg;
   logic [IdxW-1:0]         win_reg;
   logic [CntW-1:0]         beat_cnt_reg;

   logic [NoMstPorts-1:0]   cr_hs, dt_hit, drain_last;
   logic [4:0]              resp_port [NoMstPorts];
   logic [4:0]              resp_next;
   logic [NoMstPorts-1:0]   pending_next, dt_next, drain_next, win_onehot;
   logic [IdxW-1:0]         win_next;
   logic                    streaming, win_valid, win_last, win_move, beat_last;
   logic                    fifo_ok, req_ok, win_active_next;
   logic [AxiDataWidth-1:0] win_data;

   // Per-port handshakes; readies come straight from registered masks.
   for (genvar gi = 0; gi < NoMstPorts; gi++) begin : g_port
      assign cr_hs[gi]          = bus.cr_valid_i[gi] & pending_reg[gi];
      assign resp_port[gi]      = cr_hs[gi] ? bus.cr_resp_i[5*gi +: 5] : 5'd0;
      assign dt_hit[gi]         = cr_hs[gi] & bus.cr_resp_i[5*gi];
      assign drain_last[gi]     = drain_reg[gi] & bus.cd_valid_i[gi] & bus.cd_last_i[gi];
      assign bus.cr_ready_o[gi] = pending_reg[gi];
      assign bus.cd_ready_o[gi] = drain_reg[gi] | (win_move & (win_reg == IdxW'(gi)));
   end

   always_comb begin
      resp_next = resp_reg;
      for (int i = 0; i < NoMstPorts; i++) begin
         resp_next = resp_next | resp_port[i];
      end
   end

   // Scanning downwards leaves the lowest set index as the winner.
   always_comb begin
      win_next = '0;
      for (int i = NoMstPorts - 1; i >= 0; i--) begin
         if (dt_next[i]) begin
            win_next = IdxW'(i);
         end
      end
   end

   assign pending_next = pending_reg & ~cr_hs;
   assign dt_next      = dt_reg | dt_hit;
   assign win_onehot   = NoMstPorts'(1) << win_next;
   assign drain_next   = drain_reg & ~drain_last;

   assign streaming = (state_reg == STREAM) & win_active_reg;
   assign win_valid = bus.cd_valid_i[win_reg];
   assign win_last  = bus.cd_last_i[win_reg];
   assign win_data  = bus.cd_data_i[win_reg*AxiDataWidth +: AxiDataWidth];
   assign fifo_ok   = ~wb_reg | ~bus.cd_fifo_full_i;
   assign req_ok    = ~rsel_reg | bus.r_ready_i;
   assign win_move  = streaming & win_valid & req_ok & fifo_ok;
   assign beat_last = win_last | (beat_cnt_reg == CntW'(LineWords - 1));
   assign win_active_next = win_active_reg & ~(win_move & beat_last);

   assign bus.r_valid_o      = streaming & rsel_reg & win_valid & fifo_ok;
   assign bus.cd_handshake_o = streaming & wb_reg & win_valid & req_ok;
   assign bus.r_data_o       = streaming ? win_data : '0;
   assign bus.cd_o           = streaming ? win_data : '0;
   assign bus.r_last_o       = streaming & win_last;

   assign busy_o = (state_reg != IDLE);
   assign done_o = (state_reg == DONE);
   assign resp_o = done_o ? resp_reg : 5'd0;
   assign data_o = done_o & data_reg;
   assign wb_o   = done_o & wb_reg;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg      <= IDLE;
         pending_reg    <= '0;
         dt_reg         <= '0;
         drain_reg      <= '0;
         resp_reg       <= '0;
         fwd_reg        <= 1'b0;
         rsel_reg       <= 1'b0;
         wb_reg         <= 1'b0;
         data_reg       <= 1'b0;
         win_active_reg <= 1'b0;
         win_reg        <= '0;
         beat_cnt_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start_i) begin
                  pending_reg <= port_mask_i;
                  dt_reg      <= '0;
                  resp_reg    <= '0;
                  fwd_reg     <= fwd_r_i;
                  rsel_reg    <= 1'b0;
                  wb_reg      <= 1'b0;
                  data_reg    <= 1'b0;
                  state_reg   <= (port_mask_i == '0) ? DONE : COLLECT;
               end
            end
            COLLECT: begin
               pending_reg <= pending_next;
               resp_reg    <= resp_next;
               dt_reg      <= dt_next;
               if (pending_next == '0) begin
                  if (dt_next == '0) begin
                     state_reg <= DONE;
                  end else begin
                     state_reg      <= STREAM;
                     win_reg        <= win_next;
                     rsel_reg       <= fwd_reg;
                     wb_reg         <= resp_next[2];
                     data_reg       <= fwd_reg | resp_next[2];
                     beat_cnt_reg   <= '0;
                     // With no destination the winner's line is simply drained too.
                     win_active_reg <= fwd_reg | resp_next[2];
                     drain_reg      <= (fwd_reg | resp_next[2]) ? (dt_next & ~win_onehot) : dt_next;
                  end
               end
            end
            STREAM: begin
               drain_reg      <= drain_next;
               win_active_reg <= win_active_next;
               if (win_move) begin
                  beat_cnt_reg <= beat_last ? '0 : beat_cnt_reg + 1'b1;
               end
               if (!win_active_next && (drain_next == '0)) begin
                  state_reg <= DONE;
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: doc/ccu_ctrl_snoop_collector.md
Name: ccu_ctrl_snoop_collector

Overview:
- Sits directly upstream of the CCU memory unit, between the snooped caches' CR/CD channels and the requester/memory paths.
- Gathers CR responses from a masked set of snooped ports and merges their response flags.
- Streams the winning responder's CD cache line to the requester R path, to the memory unit's CD input (writeback), or to both.
- Drains CD beats from all other responders.

Parameters:
NoMstPorts, 4, number of snooped ports
AxiDataWidth, 64, CD beat width in bits
DcacheLineWidth, 128, cache line width in bits; DcacheLineWords = DcacheLineWidth/AxiDataWidth beats per line

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
start_i  in  1  start snoop collection; sampled only in IDLE
port_mask_i  in  NoMstPorts  ports expected to respond (nonzero)
fwd_r_i  in  1  forward line to requester
busy_o  out  1  high in any state other than IDLE
cr_valid_i  in  NoMstPorts  CR valid per port
cr_resp_i  in  5*NoMstPorts  CR resp per port: bit0 DataTransfer, bit1 Error, bit2 PassDirty, bit3 IsShared, bit4 WasUnique
cr_ready_o  out  NoMstPorts  CR ready per port
cd_valid_i  in  NoMstPorts  CD valid per port
cd_data_i  in  AxiDataWidth*NoMstPorts  CD data per port
cd_last_i  in  NoMstPorts  CD last per port
cd_ready_o  out  NoMstPorts  CD ready per port
r_data_o  out  AxiDataWidth  line beat to requester
r_last_o  out  1  last beat to requester
r_valid_o  out  1  requester beat valid
r_ready_i  in  1  requester ready
cd_o  out  AxiDataWidth  beat to memory unit CD FIFO
cd_handshake_o  out  1  push into memory unit CD FIFO
cd_fifo_full_i  in  1  memory unit CD FIFO full
done_o  out  1  one-cycle completion pulse
resp_o  out  5  OR of all collected CR flags, valid with done_o
data_o  out  1  a line was streamed, valid with done_o
wb_o  out  1  line was pushed to memory unit, valid with done_o

Behaviour:
- Reset: state IDLE, pending/drain masks 0; all outputs 0.
- States: IDLE, COLLECT, STREAM, DONE.
- IDLE:
  - start_i=1 -> COLLECT; pending=port_mask_i, resp accumulator 0, fwd flag latched.
  - start_i with port_mask_i=0 -> DONE directly, all results 0.
- COLLECT:
  - cr_ready_o = pending (registered; no dependence on cr_valid_i).
  - Each handshake clears its pending bit and ORs its resp into the accumulator. Several ports may complete in the same cycle.
  - If DataTransfer is set, the port's bit is set in the dt mask.
  - When pending reaches 0: dt mask = 0 -> DONE; otherwise -> STREAM.
- Entering STREAM:
  - winner = lowest index in the dt mask; drain = dt mask minus winner.
  - wb = PassDirty accumulated; rsel = fwd flag.
  - rsel=0 and wb=0 -> winner is drained too (nothing forwarded).
- STREAM, winner beat moves iff cd_valid_i[w] && (!rsel || r_ready_i) && (!wb || !cd_fifo_full_i).
  - r_valid_o = rsel && cd_valid_i[w] && (!wb || !cd_fifo_full_i).
  - cd_handshake_o = wb && cd_valid_i[w] && (!rsel || r_ready_i).
  - cd_ready_o[w] = the move condition. r_data_o = cd_o = winner data; r_last_o = cd_last_i[w].
  - Beat counter (clog2(DcacheLineWords) bits) counts winner beats. On last (cd_last_i[w] or counter = DcacheLineWords-1): winner done, counter reset to 0.
- Drained ports:
  - cd_ready_o = 1 always; a handshake with cd_last_i clears the port's drain bit.
  - Drains run in parallel with the winner and never stall it.
- STREAM -> DONE once the winner is done and the drain mask is 0, in the same cycle or later.
- DONE: done_o=1 with resp_o/data_o/wb_o valid for that one cycle -> IDLE.
  - start_i is not accepted in the DONE cycle, so the minimum turnaround is one IDLE cycle.
- No output ever holds a ready or valid for an unmasked port. CR/CD inputs on non-participating ports are ignored.
- Async reset mid-operation: return to IDLE immediately; in-flight beats are dropped.

Test Plan:
- mask=4'b0110, both CR=0x00 in the same cycle -> DONE next cycle; done_o with resp_o=0, data_o=0, wb_o=0; no CD ready asserted.
- mask=4'b0010, CR=0x05 (DT+PassDirty), fwd=1, line words 0xA,0xB -> r beats A,B (r_last on B) and cd_handshake_o for A,B; done_o with wb_o=1, resp_o=0x05.
- Same as previous with cd_fifo_full_i=1 for 3 cycles -> r_valid_o and cd_ready_o held low; no beat lost or duplicated; order A,B kept.
- mask=4'b1010, both CR=0x01, fwd=1 -> port1 is winner and goes to r; port3 is drained with no r/cd output; done_o only after both lines finish.
- mask=4'b0100, CR=0x04|0x01, fwd=0 -> only cd_handshake_o beats, r_valid_o never 1; data_o=1, wb_o=1.
- rst_ni low during STREAM after 1 beat -> all outputs 0 and state IDLE; the next start completes normally.
